// File: rtl/clk_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_cfg_sequencer                                             |
// | Brief    : Glitch-safe clock reconfiguration: gate, settle, apply,       |
// |            settle, ungate. Optional macro CLK_SEQ_COUNT_EN adds an       |
// |            8-bit saturating completed-sequence counter.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clk_cfg_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_src_sel,
  input  logic [1:0] req_int_div_sel,
  input  logic [7:0] req_frac_ratio,
  input  logic [1:0] req_func_sel,
  input  logic       dsp_en_req,
  input  logic       periph_en_req,
  output logic       clk_src_sel,
  output logic [1:0] int_div_sel,
  output logic [7:0] frac_div_ratio,
  output logic [1:0] func_clk_sel,
  output logic       div_enable,
  output logic       frac_div_enable,
  output logic       dsp_clk_en,
  output logic       periph_clk_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] seq_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GATE_OFF   = 3'd1,
    SETTLE_OFF = 3'd2,
    APPLY      = 3'd3,
    SETTLE_ON  = 3'd4,
    GATE_ON    = 3'd5
  } state_t;

  localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_load_cfg;
  logic       w_gate_off;
  logic       w_track;
  logic       w_finish;
  logic       w_accept;
  logic       w_same;
  logic [7:0] w_frac_clamped;

  logic       r_sh_src;
  logic [1:0] r_sh_div;
  logic [7:0] r_sh_frac;
  logic [1:0] r_sh_func;

  logic       r_clk_src_sel;
  logic [1:0] r_int_div_sel;
  logic [7:0] r_frac_div_ratio;
  logic [1:0] r_func_clk_sel;
  logic       r_div_enable;
  logic       r_frac_div_enable;
  logic       r_dsp_clk_en;
  logic       r_periph_clk_en;
  logic       r_done;

  assign req_ready      = (r_state == IDLE);
  assign busy           = ~req_ready;
  assign w_accept       = req_valid & req_ready;
  assign w_frac_clamped = (req_frac_ratio < 8'd2) ? 8'd2 : req_frac_ratio;

  assign w_same = (r_sh_src  == r_clk_src_sel)    &&
                  (r_sh_div  == r_int_div_sel)    &&
                  (r_sh_frac == r_frac_div_ratio) &&
                  (r_sh_func == r_func_clk_sel);

  // APPLY doubles as the final settle cycle, so S=1 still lands on E(2S+1).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_cfg  = 1'b0;
    w_gate_off  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_nxt = GATE_OFF;
      end
      GATE_OFF: begin
        if (w_same) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SETTLE_OFF;
          w_cnt_nxt   = c_settle_load;
          w_gate_off  = 1'b1;
        end
      end
      SETTLE_OFF: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = APPLY;
          w_cnt_nxt   = c_settle_load;
          w_load_cfg  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      APPLY, SETTLE_ON: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
          w_state_nxt = (r_cnt == 8'd1) ? GATE_ON : SETTLE_ON;
        end
      end
      GATE_ON: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_track  = (r_state == IDLE) || (w_state_nxt == IDLE);
  assign w_finish = (r_state != IDLE) && (w_state_nxt == IDLE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sh_src  <= 1'b0;
      r_sh_div  <= 2'd0;
      r_sh_frac <= 8'd0;
      r_sh_func <= 2'd0;
    end else if (w_accept) begin
      r_sh_src  <= req_src_sel;
      r_sh_div  <= req_int_div_sel;
      r_sh_frac <= w_frac_clamped;
      r_sh_func <= req_func_sel;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_clk_src_sel     <= 1'b0;
      r_int_div_sel     <= 2'd0;
      r_frac_div_ratio  <= 8'h10;
      r_func_clk_sel    <= 2'd0;
      r_div_enable      <= 1'b1;
      r_frac_div_enable <= 1'b1;
      r_dsp_clk_en      <= 1'b0;
      r_periph_clk_en   <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      if (w_load_cfg) begin
        r_clk_src_sel    <= r_sh_src;
        r_int_div_sel    <= r_sh_div;
        r_frac_div_ratio <= r_sh_frac;
        r_func_clk_sel   <= r_sh_func;
      end
      // Dividers only pause when their own setting is actually changing.
      if (w_gate_off) begin
        r_div_enable      <= (r_sh_div == r_int_div_sel);
        r_frac_div_enable <= (r_sh_frac == r_frac_div_ratio);
      end else if (w_finish) begin
        r_div_enable      <= 1'b1;
        r_frac_div_enable <= 1'b1;
      end
      r_dsp_clk_en    <= w_track ? dsp_en_req : 1'b0;
      r_periph_clk_en <= w_track ? periph_en_req : 1'b0;
      r_done          <= w_finish;
    end
  end

`ifdef CLK_SEQ_COUNT_EN
  logic [7:0] r_seq_count;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_seq_count <= 8'd0;
    end else if (w_finish && (r_state != GATE_OFF) && (r_seq_count != 8'hFF)) begin
      r_seq_count <= r_seq_count + 8'd1;
    end
  end

  assign seq_count = r_seq_count;
`else
  assign seq_count = 8'd0;
`endif

  assign clk_src_sel     = r_clk_src_sel;
  assign int_div_sel     = r_int_div_sel;
  assign frac_div_ratio  = r_frac_div_ratio;
  assign func_clk_sel    = r_func_clk_sel;
  assign div_enable      = r_div_enable;
  assign frac_div_enable = r_frac_div_enable;
  assign dsp_clk_en      = r_dsp_clk_en;
  assign periph_clk_en   = r_periph_clk_en;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_cfg_sequencer                                          |
// | Brief    : Scoreboard bench for clk_cfg_sequencer (CLK_SEQ_COUNT_EN aware)|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_clk_cfg_sequencer;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_src_sel;
  logic [1:0] req_int_div_sel;
  logic [7:0] req_frac_ratio;
  logic [1:0] req_func_sel;
  logic       dsp_en_req;
  logic       periph_en_req;
  logic       clk_src_sel;
  logic [1:0] int_div_sel;
  logic [7:0] frac_div_ratio;
  logic [1:0] func_clk_sel;
  logic       div_enable;
  logic       frac_div_enable;
  logic       dsp_clk_en;
  logic       periph_clk_en;
  logic       busy;
  logic       done;
  logic [7:0] seq_count;

  clk_cfg_sequencer #(.SETTLE_CYCLES(S)) u_dut (
    .clk_in          (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_src_sel     (req_src_sel),
    .req_int_div_sel (req_int_div_sel),
    .req_frac_ratio  (req_frac_ratio),
    .req_func_sel    (req_func_sel),
    .dsp_en_req      (dsp_en_req),
    .periph_en_req   (periph_en_req),
    .clk_src_sel     (clk_src_sel),
    .int_div_sel     (int_div_sel),
    .frac_div_ratio  (frac_div_ratio),
    .func_clk_sel    (func_clk_sel),
    .div_enable      (div_enable),
    .frac_div_enable (frac_div_enable),
    .dsp_clk_en      (dsp_clk_en),
    .periph_clk_en   (periph_clk_en),
    .busy            (busy),
    .done            (done),
    .seq_count       (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       src;
    logic [1:0] div;
    logic [7:0] frac;
    logic [1:0] func;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_src;
  logic [1:0] m_div;
  logic [7:0] m_frac;
  logic [1:0] m_func;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src = 1'b0; m_div = 2'd0; m_frac = 8'h10; m_func = 2'd0; m_cnt = 0;
  endtask

  // Predict the outcome of a request and queue the configuration expected at its done pulse.
  task automatic predict(input logic s, input logic [1:0] d, input logic [7:0] f,
                         input logic [1:0] fn, output logic same, output logic dsame,
                         output logic fsame);
    logic [7:0] fc;
    exp_t       e;
    fc    = (f < 8'd2) ? 8'd2 : f;
    dsame = (d == m_div);
    fsame = (fc == m_frac);
    same  = (s == m_src) && dsame && fsame && (fn == m_func);
    if (!same) begin
      m_src = s; m_div = d; m_frac = fc; m_func = fn;
      if (m_cnt < 255) m_cnt++;
    end
    e.src = m_src; e.div = m_div; e.frac = m_frac; e.func = m_func;
`ifdef CLK_SEQ_COUNT_EN
    e.cnt = 8'(m_cnt);
`else
    e.cnt = 8'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic s, input logic [1:0] d, input logic [7:0] f,
                           input logic [1:0] fn);
    req_valid = 1'b1; req_src_sel = s; req_int_div_sel = d;
    req_frac_ratio = f; req_func_sel = fn;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 64);
  endtask

  // Called one step after a clock edge with the DUT idle; walks E0..E(2S+2).
  task automatic run_seq(input logic s, input logic [1:0] d, input logic [7:0] f,
                         input logic [1:0] fn);
    logic       same, dsame, fsame;
    logic       old_src;
    logic [1:0] old_func;
    old_src  = m_src;
    old_func = m_func;
    predict(s, d, f, fn, same, dsame, fsame);
    chk("ready_pre", req_ready, 1);
    drive_req(s, d, f, fn);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_e0", busy, 1);
    if (same) begin
      chk("en_e0_same", {dsp_clk_en, periph_clk_en}, {dsp_en_req, periph_en_req});
      @(posedge clk); #1;
      chk("done_e1_same", done, 1);
      chk("en_e1_same", {dsp_clk_en, periph_clk_en}, {dsp_en_req, periph_en_req});
      chk("fen_same", frac_div_enable, 1);
    end else begin
      for (int k = 1; k <= 2 * S + 1; k++) begin
        @(posedge clk); #1;
        if (k <= 2 * S) begin
          chk("gate_low", {dsp_clk_en, periph_clk_en}, 0);
          chk("sel_phase", {clk_src_sel, func_clk_sel},
              (k <= S) ? {old_src, old_func} : {s, fn});
          chk("frac_en_gap", frac_div_enable, fsame);
          chk("div_en_gap", div_enable, dsame);
          chk("done_early", done, 0);
        end else begin
          chk("gate_resume", {dsp_clk_en, periph_clk_en}, {dsp_en_req, periph_en_req});
          chk("done_end", done, 1);
          chk("enables_end", {div_enable, frac_div_enable}, 2'b11);
        end
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_cfg", {clk_src_sel, int_div_sel, frac_div_ratio, func_clk_sel},
            {e.src, e.div, e.frac, e.func});
        chk("sb_seq_count", seq_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic same, dsame, fsame;
    rst = 1'b1; req_valid = 1'b0; req_src_sel = 1'b0; req_int_div_sel = 2'd0;
    req_frac_ratio = 8'd0; req_func_sel = 2'd0; dsp_en_req = 1'b0; periph_en_req = 1'b0;
    model_reset();
    #2;
    chk("rst_cfg", {clk_src_sel, int_div_sel, frac_div_ratio, func_clk_sel},
        {1'b0, 2'd0, 8'h10, 2'd0});
    chk("rst_en", {div_enable, frac_div_enable, dsp_clk_en, periph_clk_en}, 4'b1100);
    chk("rst_flags", {done, busy, seq_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_first", req_ready, 1);
    dsp_en_req = 1'b1;
    @(posedge clk); #1;
    chk("dsp_track", {dsp_clk_en, periph_clk_en}, 2'b10);
    periph_en_req = 1'b1;
    @(posedge clk); #1;
    chk("periph_track", {dsp_clk_en, periph_clk_en}, 2'b11);

    run_seq(1'b1, 2'd0, 8'h10, 2'd2);   // source + functional select change
    run_seq(1'b1, 2'd0, 8'h10, 2'd2);   // identical request, no gating
    run_seq(1'b1, 2'd2, 8'h00, 2'd2);   // frac 0 clamps to 2, divider changes
    run_seq(1'b1, 2'd2, 8'h01, 2'd2);   // frac 1 clamps to 2, now identical

    // Second request held through the first sequence.
    predict(1'b0, 2'd3, 8'h40, 2'd1, same, dsame, fsame);
    predict(1'b1, 2'd1, 8'h80, 2'd0, same, dsame, fsame);
    drive_req(1'b0, 2'd3, 8'h40, 2'd1);
    @(posedge clk); #1;
    drive_req(1'b1, 2'd1, 8'h80, 2'd0);
    wait_done(n);
    chk("b2b_first_latency", n, 2 * S + 1);
    chk("b2b_ready_on_done", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_second_started", busy, 1);
    wait_done(n);
    chk("b2b_second_latency", n, 2 * S + 1);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", done, 0);

    // Reset in the middle of a sequence, between clock edges.
    drive_req(1'b0, 2'd1, 8'h33, 2'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg", {clk_src_sel, int_div_sel, frac_div_ratio, func_clk_sel},
        {1'b0, 2'd0, 8'h10, 2'd0});
    chk("arst_en", {div_enable, frac_div_enable, dsp_clk_en, periph_clk_en}, 4'b1100);
    chk("arst_flags", {done, busy, req_ready}, 3'b001);
    chk("arst_count", seq_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("arst_no_done", done, 0);
    chk("arst_track", {dsp_clk_en, periph_clk_en}, 2'b11);

    run_seq(1'b0, 2'd1, 8'hFF, 2'd3);
    repeat (2) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
